seq_detect_prog: RTL and testbench
==================================

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, meaning the maximum pattern length in bits (legal range 4..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the match counter width.
REQ-003 The block SHALL have derived constant LEN_W = clog2(MAX_LEN+1), meaning the length field width.
REQ-004 Port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, meaning the reset; it SHALL be synchronous and active-high.
REQ-006 Port din, input, 1, meaning the serial data bit.
REQ-007 Port din_valid, input, 1, meaning din is sampled this cycle.
REQ-008 Port cfg_load, input, 1, meaning a one-cycle strobe that loads the configuration.
REQ-009 Port cfg_pattern, input, MAX_LEN, meaning the pattern; bit [len-1] is the first bit received and bit [0] is the last.
REQ-010 Port cfg_len, input, LEN_W, meaning the pattern length.
REQ-011 Port cfg_overlap, input, 1, meaning 1 = overlapping detection and 0 = non-overlapping detection.
REQ-012 Port clr_count, input, 1, meaning clear the match counter.
REQ-013 Port dout, output, 1, meaning the Mealy match pulse.
REQ-014 Port match_count, output, CNT_W, meaning the number of matches.
REQ-015 Port count_sat, output, 1, meaning match_count is saturated.
REQ-016 Port cfg_err, output, 1, meaning the last cfg_load was rejected.

Function
REQ-017 Active configuration SHALL be held in registers pat_r, len_r and ovl_r.
REQ-018 The block SHALL hold a history shift register hist of MAX_LEN-1 bits and a fill counter fill that saturates at len_r-1.
REQ-019 dout SHALL be combinational (Mealy, zero latency) and equal 1 iff all of the following hold:
- din_valid = 1;
- cfg_load = 0;
- fill >= len_r-1;
- {hist[len_r-2:0], din} == pat_r[len_r-1:0].
REQ-020 On a cycle with din_valid=1 and cfg_load=0, hist SHALL shift left, taking din into bit 0, and fill SHALL increment (saturating).
REQ-021 When dout=1 and ovl_r=1, fill SHALL remain saturated so that overlapping matches are detected.
REQ-022 When dout=1 and ovl_r=0, fill SHALL be cleared to 0 on the next edge and the matching bit SHALL NOT be reused.
REQ-023 On a cycle with din_valid=0, hist and fill SHALL hold and dout SHALL be 0.
REQ-024 A cfg_load with 1 <= cfg_len <= MAX_LEN SHALL load pat_r/len_r/ovl_r, clear fill and hist, and clear cfg_err, all on the next edge.
REQ-025 A cfg_load with cfg_len = 0 or cfg_len > MAX_LEN SHALL leave the configuration, hist and fill unchanged and set cfg_err.
REQ-026 cfg_err SHALL remain set until the next valid cfg_load or reset.
REQ-027 When cfg_load and din_valid are both 1 in the same cycle, cfg_load SHALL win: din is discarded and dout = 0.
REQ-028 With len_r = 1, dout SHALL equal din_valid & (din == pat_r[0]), and hist SHALL be unused.
REQ-029 match_count SHALL increment by 1 on the edge following each dout=1 cycle, and saturate at 2^CNT_W-1.
REQ-030 count_sat SHALL equal 1 while match_count equals 2^CNT_W-1.
REQ-031 When clr_count=1, match_count SHALL be 0 on the next edge, taking priority over a simultaneous match increment.
REQ-032 cfg_load SHALL NOT alter match_count.

Reset
REQ-033 While reset=1, on each edge, all registers SHALL take the following values:
- pat_r = 4'b1101 zero-extended;
- len_r = 4;
- ovl_r = 1;
- hist = 0;
- fill = 0;
- match_count = 0;
- cfg_err = 0.
REQ-034 reset SHALL have priority over cfg_load, clr_count and din_valid.
REQ-035 Reset asserted in the middle of a partial match SHALL discard that match, so that no dout occurs until a full new pattern is received.
REQ-036 While reset=1, dout SHALL be 0.

Structure
REQ-037 Package seq_detect_pkg SHALL contain the reset defaults (DEF_PATTERN, DEF_LEN, DEF_OVERLAP) and the LEN_W width helper.
REQ-038 The saturating counter with clear SHALL be implemented as sub-module match_counter (parameter CNT_W; ports inc, clr, count, sat).
REQ-039 The history, fill and compare logic SHALL reside in the top module.

Verification
REQ-040 Reset defaults, din_valid=1, stream 1,1,0,1,1,0,1 -> dout=1 on the 4th and 7th bits; match_count = 2.
REQ-041 cfg_load with pattern 8'b10101010, len 8, overlap 0; stream 1010101010101010 -> dout on bits 8 and 16 only; with overlap 1 -> dout on bits 8, 10, 12, 14 and 16.
REQ-042 cfg_len = 0 and cfg_len = MAX_LEN+1 loads -> cfg_err=1, the 1101 pattern is still detected; a subsequent valid load -> cfg_err=0.
REQ-043 Stream 1,1,0 followed by cfg_load and din_valid together with din=1 -> dout=0, and a fresh 1101 is required for the next match.
REQ-044 CNT_W=3, nine matches -> match_count = 7 and count_sat=1; clr_count asserted in the same cycle as a match -> match_count = 0.
REQ-045 Stream 1,1,0, then reset for 1 cycle, then 1 -> no dout; din_valid gaps inside 1101 -> a single match is still detected.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared constants for the programmable serial pattern detector:
// reset-time configuration and the length-field width helper.
package seq_detect_pkg;

    localparam logic [31:0] DEF_PATTERN = 32'b1101;
    localparam int          DEF_LEN     = 4;
    localparam logic        DEF_OVERLAP = 1'b1;

    // Width needed to hold a length value in the range 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_detect_prog_match_counter.sv
// Saturating match counter with a synchronous clear that outranks increment.
module match_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !sat) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign sat   = &r_count;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector: Mealy match pulse on the last bit of
// the configured pattern, optional overlap, plus a saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               dout,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic               r_cfg_err;

    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_cfg_ok;
    logic               w_shift;
    logic               w_full;
    logic               w_hit;

    // The window is the last len_r bits seen, newest in bit 0; bits above
    // len_r are masked out so a single compare covers every length.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(len_r));
        end
        w_window = {hist, din};
        w_cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        w_shift  = din_valid && !cfg_load && !reset;
        w_full   = (fill >= (len_r - LEN_W'(1)));
        w_hit    = (((w_window ^ pat_r) & w_mask) == '0);
        dout     = w_shift && w_full && w_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r     <= MAX_LEN'(DEF_PATTERN);
            len_r     <= LEN_W'(DEF_LEN);
            ovl_r     <= DEF_OVERLAP;
            hist      <= '0;
            fill      <= '0;
            r_cfg_err <= 1'b0;
        end else if (cfg_load) begin
            // A rejected load keeps the old configuration and stream state.
            if (w_cfg_ok) begin
                pat_r     <= cfg_pattern;
                len_r     <= cfg_len;
                ovl_r     <= cfg_overlap;
                hist      <= '0;
                fill      <= '0;
                r_cfg_err <= 1'b0;
            end else begin
                r_cfg_err <= 1'b1;
            end
        end else if (w_shift) begin
            hist <= {hist[MAX_LEN-3:0], din};
            if (dout && !ovl_r) begin
                fill <= '0;
            end else if (!w_full) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

    assign cfg_err = r_cfg_err;

    match_counter #(
        .CNT_W(CNT_W)
    ) u_match_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (dout),
        .clr  (clr_count),
        .count(match_count),
        .sat  (count_sat)
    );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus random traffic, all
// checked against a bit-queue reference model of the detector.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               din;
    logic               din_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clr_count;

    logic               dout;
    logic [15:0]        match_count;
    logic               count_sat;
    logic               cfg_err;
    logic               dout_c3;
    logic [2:0]         match_count_c3;
    logic               count_sat_c3;
    logic               cfg_err_c3;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: bits received since the last restart.
    logic               exp_q[$];
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    logic               m_ovl;
    logic               m_err;
    int                 m_cnt16;
    int                 m_cnt3;

    always #5 clk = ~clk;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count), .dout(dout),
        .match_count(match_count), .count_sat(count_sat), .cfg_err(cfg_err)
    );

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(3)) dut_c3 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count), .dout(dout_c3),
        .match_count(match_count_c3), .count_sat(count_sat_c3), .cfg_err(cfg_err_c3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pat   = 8'b0000_1101;
        m_len   = 4;
        m_ovl   = 1'b1;
        m_err   = 1'b0;
        m_cnt16 = 0;
        m_cnt3  = 0;
    endtask

    // Match if the newest m_len bits (history then din) spell the pattern,
    // with pattern bit [len-1] being the oldest of them.
    function automatic logic model_dout();
        int sz;
        if (reset || !din_valid || cfg_load) return 1'b0;
        sz = exp_q.size();
        if (sz + 1 < m_len) return 1'b0;
        if (din != m_pat[0]) return 1'b0;
        for (int k = 1; k < m_len; k++) begin
            if (exp_q[sz-k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_update(input logic hit);
        int ln;
        if (reset) begin
            model_reset();
            return;
        end
        if (clr_count) begin
            m_cnt16 = 0;
            m_cnt3  = 0;
        end else if (hit) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt3 < 7) m_cnt3++;
        end
        if (cfg_load) begin
            ln = int'(cfg_len);
            if (ln >= 1 && ln <= MAX_LEN) begin
                m_pat = cfg_pattern;
                m_len = ln;
                m_ovl = cfg_overlap;
                m_err = 1'b0;
                exp_q.delete();
            end else begin
                m_err = 1'b1;
            end
        end else if (din_valid) begin
            if (hit && !m_ovl) begin
                exp_q.delete();
            end else begin
                exp_q.push_back(din);
                if (exp_q.size() > MAX_LEN) void'(exp_q.pop_front());
            end
        end
    endtask

    // One clock: compare at the falling edge, then advance model and DUT.
    task automatic tick();
        logic e;
        @(negedge clk);
        e = model_dout();
        check("dout", dout, e);
        check("dout_c3", dout_c3, e);
        check("match_count", match_count, m_cnt16);
        check("match_count_c3", match_count_c3, m_cnt3);
        check("count_sat", count_sat, m_cnt16 == 65535);
        check("count_sat_c3", count_sat_c3, m_cnt3 == 7);
        check("cfg_err", cfg_err, m_err);
        check("cfg_err_c3", cfg_err_c3, m_err);
        model_update(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset       = 1'b0;
        din         = 1'b0;
        din_valid   = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        clr_count   = 1'b0;
    endtask

    task automatic send_bit(input logic d);
        idle_inputs();
        din_valid = 1'b1;
        din       = d;
        tick();
    endtask

    task automatic send_gap();
        idle_inputs();
        tick();
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input int len, input logic ovl,
                            input logic v, input logic d);
        idle_inputs();
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        din_valid   = v;
        din         = d;
        tick();
    endtask

    task automatic pulse_reset(input logic v, input logic d);
        idle_inputs();
        reset     = 1'b1;
        din_valid = v;
        din       = d;
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        pulse_reset(1'b1, 1'b1);

        // Default 1101 overlapping: hits on bits 4 and 7.
        send_bits(32'b1101101, 7);
        check("req040_count", match_count, 2);

        // 8-bit alternating pattern, non-overlapping then overlapping.
        load_cfg(8'b1010_1010, 8, 1'b0, 1'b0, 1'b0);
        send_bits(32'hAAAA, 16);
        check("req041_novl_count", match_count, 4);
        load_cfg(8'b1010_1010, 8, 1'b1, 1'b0, 1'b0);
        send_bits(32'hAAAA, 16);
        check("req041_ovl_count", match_count, 9);

        // Rejected loads keep the old configuration.
        load_cfg(8'b1101, 4, 1'b1, 1'b0, 1'b0);
        load_cfg(8'hFF, 0, 1'b0, 1'b0, 1'b0);
        check("req042_err_len0", cfg_err, 1);
        load_cfg(8'hFF, MAX_LEN + 1, 1'b0, 1'b0, 1'b0);
        check("req042_err_len9", cfg_err, 1);
        send_bits(32'b1101, 4);
        load_cfg(8'b1101, 4, 1'b1, 1'b0, 1'b0);
        check("req042_err_clear", cfg_err, 0);

        // Load collides with a valid bit that would otherwise complete 1101.
        send_bits(32'b110, 3);
        load_cfg(8'b1101, 4, 1'b1, 1'b1, 1'b1);
        send_bits(32'b1101, 4);

        // Saturation of the narrow counter, then clear racing a match.
        idle_inputs();
        clr_count = 1'b1;
        tick();
        send_bits(32'b1101, 4);
        for (int i = 0; i < 8; i++) send_bits(32'b101, 3);
        check("req044_count_c3", match_count_c3, 7);
        check("req044_sat_c3", count_sat_c3, 1);
        send_bits(32'b110, 3);
        idle_inputs();
        din_valid = 1'b1;
        din       = 1'b1;
        clr_count = 1'b1;
        tick();
        check("req044_clr_c3", match_count_c3, 0);
        check("req044_clr", match_count, 0);

        // Reset mid-pattern, then gaps inside a pattern.
        send_bits(32'b110, 3);
        pulse_reset(1'b1, 1'b1);
        send_bit(1'b1);
        send_bit(1'b1); send_gap(); send_bit(1'b1); send_gap();
        send_bit(1'b0); send_gap(); send_gap(); send_bit(1'b1);

        // Length-1 patterns in both overlap modes.
        load_cfg(8'h01, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        load_cfg(8'h00, 1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));

        // Random traffic with occasional loads, clears and resets.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 199);
            idle_inputs();
            if (r < 2) begin
                reset     = 1'b1;
                din_valid = 1'($urandom_range(0, 1));
                din       = 1'($urandom_range(0, 1));
            end else if (r < 8) begin
                cfg_load    = 1'b1;
                cfg_pattern = MAX_LEN'($urandom);
                cfg_len     = ($urandom_range(0, 1) == 1) ? LEN_W'($urandom_range(1, 4))
                                                          : LEN_W'($urandom_range(0, 15));
                cfg_overlap = 1'($urandom_range(0, 1));
                din_valid   = 1'($urandom_range(0, 1));
                din         = 1'($urandom_range(0, 1));
            end else begin
                din_valid = ($urandom_range(0, 9) < 8);
                din       = 1'($urandom_range(0, 1));
                clr_count = ($urandom_range(0, 49) == 0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
